// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode codes and the entry record for the reservation station.
// Optional feature macro: RS_ISSUE_BYPASS_EN (capture same-cycle CDB values at issue).
package reservation_station_pkg;

    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam int OP_W    = 6;
    localparam int IDX_W   = $clog2(RS_SIZE);

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_BEQ   = 6'd3,
        OP_JALR  = 6'd4,
        OP_LOAD  = 6'd5,
        OP_STORE = 6'd6
    } op_e;

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  opcode;
        logic [ROB_W-1:0] rob;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
        logic             j_rdy;
        logic             k_rdy;
    } rs_entry_t;

    // A broadcast only counts when its valid strobe is up.
    function automatic logic tag_hit(input logic sgn, input logic [ROB_W-1:0] cdb_rob,
                                     input logic [ROB_W-1:0] tag);
        return sgn && (cdb_rob == tag);
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB snoop and dispatch bundle of the reservation station.
// master = issuer/environment side, slave = reservation station side.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic             rdy;
    logic             flush;
    logic             iss_valid;
    logic [OP_W-1:0]  iss_opcode;
    logic [ROB_W-1:0] iss_rob;
    logic [31:0]      iss_vj;
    logic [31:0]      iss_vk;
    logic [ROB_W-1:0] iss_qj;
    logic [ROB_W-1:0] iss_qk;
    logic             iss_qj_rdy;
    logic             iss_qk_rdy;
    logic             full;
    logic             alu_cdb_sgn;
    logic [ROB_W-1:0] alu_cdb_rob;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_sgn;
    logic [ROB_W-1:0] lsb_cdb_rob;
    logic [31:0]      lsb_cdb_val;
    logic             RS_sgn;
    logic [OP_W-1:0]  RS_opcode;
    logic [ROB_W-1:0] RS_ROB_name;
    logic [31:0]      RS_lhs;
    logic [31:0]      RS_rhs;

    modport master (
        output rdy, flush, iss_valid, iss_opcode, iss_rob, iss_vj, iss_vk,
               iss_qj, iss_qk, iss_qj_rdy, iss_qk_rdy,
               alu_cdb_sgn, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val,
        input  full, RS_sgn, RS_opcode, RS_ROB_name, RS_lhs, RS_rhs
    );

    modport slave (
        input  rdy, flush, iss_valid, iss_opcode, iss_rob, iss_vj, iss_vk,
               iss_qj, iss_qk, iss_qj_rdy, iss_qk_rdy,
               alu_cdb_sgn, alu_cdb_rob, alu_cdb_val,
               lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val,
        output full, RS_sgn, RS_opcode, RS_ROB_name, RS_lhs, RS_rhs
    );

endinterface

// File: rtl/reservation_station_rs_select.sv
// Lowest-index priority encoder; used for both free-slot and ready-slot picking.
module rs_select #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds ALU-class instructions until both operands are
// valid, snoops ALU and load-buffer CDBs, dispatches one ready entry per cycle.
// Optional feature macro: RS_ISSUE_BYPASS_EN (issue-time capture of same-cycle CDB).
module reservation_station
    import reservation_station_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    reservation_station_if.slave bus
);

    rs_entry_t        ent_q [RS_SIZE];
    rs_entry_t        ent_d [RS_SIZE];
    rs_entry_t        new_ent;
    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic [IDX_W-1:0] free_idx, ready_idx;
    logic             free_found, ready_found, full;
    logic             sgn_q, sgn_d;
    logic [OP_W-1:0]  opcode_q, opcode_d;
    logic [ROB_W-1:0] rob_q, rob_d;
    logic [31:0]      lhs_q, lhs_d, rhs_q, rhs_d;

    // Slot status vectors, taken from registered state only (pre-wakeup).
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = ~ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ent_q[i].j_rdy & ent_q[i].k_rdy;
        end
    end

    rs_select #(.N(RS_SIZE)) u_free_sel  (.req_i(free_vec),  .idx_o(free_idx),  .found_o(free_found));
    rs_select #(.N(RS_SIZE)) u_ready_sel (.req_i(ready_vec), .idx_o(ready_idx), .found_o(ready_found));

    assign full = ~free_found;

    // Build the incoming entry; with bypass, a pending operand whose producer is on a CDB this cycle is captured.
    always_comb begin
        new_ent        = '0;
        new_ent.busy   = 1'b1;
        new_ent.opcode = bus.iss_opcode;
        new_ent.rob    = bus.iss_rob;
        new_ent.vj     = bus.iss_vj;
        new_ent.vk     = bus.iss_vk;
        new_ent.qj     = bus.iss_qj;
        new_ent.qk     = bus.iss_qk;
        new_ent.j_rdy  = bus.iss_qj_rdy;
        new_ent.k_rdy  = bus.iss_qk_rdy;
`ifdef RS_ISSUE_BYPASS_EN
        if (!bus.iss_qj_rdy) begin
            if (tag_hit(bus.alu_cdb_sgn, bus.alu_cdb_rob, bus.iss_qj)) begin
                new_ent.vj = bus.alu_cdb_val; new_ent.j_rdy = 1'b1;
            end else if (tag_hit(bus.lsb_cdb_sgn, bus.lsb_cdb_rob, bus.iss_qj)) begin
                new_ent.vj = bus.lsb_cdb_val; new_ent.j_rdy = 1'b1;
            end
        end
        if (!bus.iss_qk_rdy) begin
            if (tag_hit(bus.alu_cdb_sgn, bus.alu_cdb_rob, bus.iss_qk)) begin
                new_ent.vk = bus.alu_cdb_val; new_ent.k_rdy = 1'b1;
            end else if (tag_hit(bus.lsb_cdb_sgn, bus.lsb_cdb_rob, bus.iss_qk)) begin
                new_ent.vk = bus.lsb_cdb_val; new_ent.k_rdy = 1'b1;
            end
        end
`endif
    end

    // Next state: wakeup, select/dispatch, issue, flush; rdy=0 freezes entries and drops RS_sgn.
    always_comb begin
        ent_d    = ent_q;
        sgn_d    = 1'b0;
        opcode_d = opcode_q;
        rob_d    = rob_q;
        lhs_d    = lhs_q;
        rhs_d    = rhs_q;
        if (bus.rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy && !ent_q[i].j_rdy) begin
                    if (tag_hit(bus.alu_cdb_sgn, bus.alu_cdb_rob, ent_q[i].qj)) begin
                        ent_d[i].vj = bus.alu_cdb_val; ent_d[i].j_rdy = 1'b1;
                    end else if (tag_hit(bus.lsb_cdb_sgn, bus.lsb_cdb_rob, ent_q[i].qj)) begin
                        ent_d[i].vj = bus.lsb_cdb_val; ent_d[i].j_rdy = 1'b1;
                    end
                end
                if (ent_q[i].busy && !ent_q[i].k_rdy) begin
                    if (tag_hit(bus.alu_cdb_sgn, bus.alu_cdb_rob, ent_q[i].qk)) begin
                        ent_d[i].vk = bus.alu_cdb_val; ent_d[i].k_rdy = 1'b1;
                    end else if (tag_hit(bus.lsb_cdb_sgn, bus.lsb_cdb_rob, ent_q[i].qk)) begin
                        ent_d[i].vk = bus.lsb_cdb_val; ent_d[i].k_rdy = 1'b1;
                    end
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
            end else begin
                if (ready_found) begin
                    sgn_d                 = 1'b1;
                    opcode_d              = ent_q[ready_idx].opcode;
                    rob_d                 = ent_q[ready_idx].rob;
                    lhs_d                 = ent_q[ready_idx].vj;
                    rhs_d                 = ent_q[ready_idx].vk;
                    ent_d[ready_idx].busy = 1'b0;
                end
                // Free slot comes from registered state, so it never collides with the dispatched slot.
                if (bus.iss_valid && !full) ent_d[free_idx] = new_ent;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            sgn_q    <= 1'b0;
            opcode_q <= '0;
            rob_q    <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
        end else begin
            ent_q    <= ent_d;
            sgn_q    <= sgn_d;
            opcode_q <= opcode_d;
            rob_q    <= rob_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
        end
    end

    assign bus.full        = full;
    assign bus.RS_sgn      = sgn_q;
    assign bus.RS_opcode   = opcode_q;
    assign bus.RS_ROB_name = rob_q;
    assign bus.RS_lhs      = lhs_q;
    assign bus.RS_rhs      = rhs_q;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by
// random traffic, all compared against a behavioural model of the station.
module tb_reservation_station;
    import reservation_station_pkg::*;

`ifdef RS_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        bit        busy;
        bit [5:0]  op;
        bit [3:0]  rob;
        bit [31:0] vj;
        bit [31:0] vk;
        bit [3:0]  qj;
        bit [3:0]  qk;
        bit        jr;
        bit        kr;
    } m_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    reservation_station_if bus ();

    reservation_station dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    m_ent_t    m [8];
    bit        e_sgn;
    bit [5:0]  e_op;
    bit [3:0]  e_rob;
    bit [31:0] e_lhs, e_rhs;
    int        n_cmp = 0;
    int        n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // CDB lookup for a tag; the ALU bus takes precedence over the load buffer.
    task automatic cdb_lookup(input bit [3:0] tag, output bit hit, output bit [31:0] val);
        hit = 1'b0; val = 32'd0;
        if (bus.alu_cdb_sgn && bus.alu_cdb_rob == tag) begin hit = 1'b1; val = bus.alu_cdb_val; end
        else if (bus.lsb_cdb_sgn && bus.lsb_cdb_rob == tag) begin hit = 1'b1; val = bus.lsb_cdb_val; end
    endtask

    // One clock of the reference behaviour using the inputs currently driven.
    task automatic model_step();
        m_ent_t nm [8];
        int sel, slot;
        bit hit, was_full;
        bit [31:0] v;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m[i] = '0;
            e_sgn = 0; e_op = 0; e_rob = 0; e_lhs = 0; e_rhs = 0;
            return;
        end
        if (!bus.rdy) begin e_sgn = 0; return; end
        was_full = m_full();
        sel = -1;
        for (int i = 0; i < 8; i++)
            if (sel < 0 && m[i].busy && m[i].jr && m[i].kr) sel = i;
        nm = m;
        for (int i = 0; i < 8; i++) begin
            if (!m[i].busy) continue;
            if (!m[i].jr) begin cdb_lookup(m[i].qj, hit, v); if (hit) begin nm[i].vj = v; nm[i].jr = 1; end end
            if (!m[i].kr) begin cdb_lookup(m[i].qk, hit, v); if (hit) begin nm[i].vk = v; nm[i].kr = 1; end end
        end
        if (bus.flush) begin
            for (int i = 0; i < 8; i++) nm[i].busy = 0;
            e_sgn = 0;
        end else begin
            if (sel >= 0) begin
                e_sgn = 1; e_op = m[sel].op; e_rob = m[sel].rob;
                e_lhs = m[sel].vj; e_rhs = m[sel].vk;
                nm[sel].busy = 0;
            end else e_sgn = 0;
            if (bus.iss_valid && !was_full) begin
                slot = -1;
                for (int i = 0; i < 8; i++) if (slot < 0 && !m[i].busy) slot = i;
                nm[slot] = '{busy: 1, op: bus.iss_opcode, rob: bus.iss_rob, vj: bus.iss_vj,
                             vk: bus.iss_vk, qj: bus.iss_qj, qk: bus.iss_qk,
                             jr: bus.iss_qj_rdy, kr: bus.iss_qk_rdy};
                if (BYPASS && !bus.iss_qj_rdy) begin
                    cdb_lookup(bus.iss_qj, hit, v); if (hit) begin nm[slot].vj = v; nm[slot].jr = 1; end
                end
                if (BYPASS && !bus.iss_qk_rdy) begin
                    cdb_lookup(bus.iss_qk, hit, v); if (hit) begin nm[slot].vk = v; nm[slot].kr = 1; end
                end
            end
        end
        m = nm;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("sgn",    bus.RS_sgn,      e_sgn);
        chk("full",   bus.full,        m_full());
        chk("opcode", bus.RS_opcode,   e_op);
        chk("rob",    bus.RS_ROB_name, e_rob);
        chk("lhs",    bus.RS_lhs,      e_lhs);
        chk("rhs",    bus.RS_rhs,      e_rhs);
    endtask

    task automatic idle();
        bus.rdy = 1; bus.flush = 0; bus.iss_valid = 0;
        bus.iss_opcode = 0; bus.iss_rob = 0; bus.iss_vj = 0; bus.iss_vk = 0;
        bus.iss_qj = 0; bus.iss_qk = 0; bus.iss_qj_rdy = 0; bus.iss_qk_rdy = 0;
        bus.alu_cdb_sgn = 0; bus.alu_cdb_rob = 0; bus.alu_cdb_val = 0;
        bus.lsb_cdb_sgn = 0; bus.lsb_cdb_rob = 0; bus.lsb_cdb_val = 0;
    endtask

    task automatic issue(input bit [5:0] op, input bit [3:0] rob, input bit [31:0] vj,
                         input bit [31:0] vk, input bit [3:0] qj, input bit [3:0] qk,
                         input bit jr, input bit kr);
        bus.iss_valid = 1; bus.iss_opcode = op; bus.iss_rob = rob;
        bus.iss_vj = vj; bus.iss_vk = vk; bus.iss_qj = qj; bus.iss_qk = qk;
        bus.iss_qj_rdy = jr; bus.iss_qk_rdy = kr;
    endtask

    initial begin
        idle();
        // Reset held two cycles
        rst = 0;
        step(); step();
        chk("rst_sgn",  bus.RS_sgn, 0);
        chk("rst_full", bus.full,   0);
        chk("rst_lhs",  bus.RS_lhs, 0);
        chk("rst_rob",  bus.RS_ROB_name, 0);
        rst = 1;

        // Both operands ready: dispatch on the edge after issue
        issue(OP_ADD, 4'd3, 32'd5, 32'd7, 0, 0, 1, 1);
        step();
        chk("add_not_yet", bus.RS_sgn, 0);
        idle(); step();
        chk("add_sgn", bus.RS_sgn, 1);
        chk("add_lhs", bus.RS_lhs, 5);
        chk("add_rhs", bus.RS_rhs, 7);
        chk("add_rob", bus.RS_ROB_name, 3);
        idle(); step();

        // Pending operand woken by the ALU CDB
        issue(OP_SUB, 4'd4, 32'd0, 32'd1, 4'd3, 0, 0, 1);
        step();
        idle(); bus.alu_cdb_sgn = 1; bus.alu_cdb_rob = 3; bus.alu_cdb_val = 32'd12;
        step();
        chk("sub_wait", bus.RS_sgn, 0);
        idle(); step();
        chk("sub_sgn", bus.RS_sgn, 1);
        chk("sub_lhs", bus.RS_lhs, 12);
        idle(); step();

        // Fill all eight entries with pending operands, drop a ninth
        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, 4'(i + 8), 32'd0, 32'd2, 4'(i), 0, 0, 1);
            step();
        end
        chk("fill_full", bus.full, 1);
        issue(OP_ADD, 4'd9, 32'd1, 32'd1, 0, 0, 1, 1);
        step();
        chk("drop_full", bus.full, 1);
        idle(); bus.lsb_cdb_sgn = 1; bus.lsb_cdb_rob = 0; bus.lsb_cdb_val = 32'd100;
        step();
        idle(); step();
        chk("drain_sgn",  bus.RS_sgn, 1);
        chk("drain_lhs",  bus.RS_lhs, 100);
        chk("drain_full", bus.full, 0);

        // Flush with busy entries and a simultaneous issue
        issue(OP_ADD, 4'd1, 32'd1, 32'd1, 0, 0, 1, 1);
        bus.flush = 1;
        step();
        chk("flush_sgn",  bus.RS_sgn, 0);
        chk("flush_full", bus.full, 0);
        idle(); step();
        chk("flush_no_dispatch", bus.RS_sgn, 0);

        // rdy low freezes a ready entry and forces RS_sgn low
        issue(OP_BEQ, 4'd2, 32'd4, 32'd4, 0, 0, 1, 1);
        step();
        idle(); bus.rdy = 0; step();
        chk("frz_sgn", bus.RS_sgn, 0);
        step();
        idle(); step();
        chk("thaw_sgn", bus.RS_sgn, 1);
        chk("thaw_op",  bus.RS_opcode, OP_BEQ);

        // Same-cycle CDB at issue
        issue(OP_JALR, 4'd7, 32'd0, 32'd3, 4'd6, 0, 0, 1);
        bus.alu_cdb_sgn = 1; bus.alu_cdb_rob = 6; bus.alu_cdb_val = 32'd9;
        step();
        idle(); step();
        chk("byp_sgn", bus.RS_sgn, BYPASS);
        idle(); bus.flush = 1; step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 199) != 0);
            bus.rdy = ($urandom_range(0, 9) != 0);
            bus.flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1)
                issue(6'($urandom_range(0, 6)), 4'($urandom), $urandom, $urandom,
                      4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            bus.alu_cdb_sgn = 1'($urandom); bus.alu_cdb_rob = 4'($urandom); bus.alu_cdb_val = $urandom;
            bus.lsb_cdb_sgn = 1'($urandom); bus.lsb_cdb_rob = 4'($urandom); bus.lsb_cdb_val = $urandom;
            step();
        end
        rst = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
